// File: rtl/rv_addr_line_en_target_regs.sv
// Responder end of the rv_addr_line_en register protocol: one request at a time,
// optional wait states, then a single-cycle access to a small register file.
module rv_addr_line_en_target_regs #(
    parameter int                   ADR_WIDTH   = 4,
    parameter int                   DAT_WIDTH   = 32,
    parameter int                   N_REGS      = 8,
    parameter int                   WAIT_STATES = 0,
    parameter logic [DAT_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ADR_WIDTH-1:0]          rt_adr,
    input  logic [DAT_WIDTH-1:0]          rt_dat_w,
    input  logic                          rt_we,
    input  logic                          rt_valid,
    output logic                          rt_ready,
    output logic [DAT_WIDTH-1:0]          rt_dat_r,
    output logic                          rt_err,
    output logic                          rt_rsp_valid,
    input  logic                          rt_rsp_ready,
    output logic [N_REGS*DAT_WIDTH-1:0]   regs_o,
    output logic [N_REGS-1:0]             wr_stb_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [7:0]         WAIT_INIT = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;
    localparam logic [ADR_WIDTH:0] N_REGS_L  = (ADR_WIDTH + 1)'(N_REGS);

    state_t                 state_reg, state_next;
    logic [7:0]             cnt_reg, cnt_next;
    logic                   rt_ready_reg, rt_ready_next;
    logic                   rsp_valid_reg, rsp_valid_next;
    logic [DAT_WIDTH-1:0]   dat_r_reg, dat_r_next;
    logic                   err_reg, err_next;
    logic [ADR_WIDTH-1:0]   adr_reg, adr_next;
    logic [DAT_WIDTH-1:0]   dat_w_reg, dat_w_next;
    logic                   we_reg, we_next;

    logic [DAT_WIDTH-1:0]   regs_reg [N_REGS];
    logic [N_REGS-1:0]      wr_stb;
    logic [DAT_WIDTH-1:0]   rd_data;
    logic                   mapped;

    assign mapped = ({1'b0, adr_reg} < N_REGS_L);

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (adr_reg == ADR_WIDTH'(k)) begin
                rd_data = regs_reg[k];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rt_ready_next  = rt_ready_reg;
        rsp_valid_next = rsp_valid_reg;
        dat_r_next     = dat_r_reg;
        err_next       = err_reg;
        adr_next       = adr_reg;
        dat_w_next     = dat_w_reg;
        we_next        = we_reg;
        case (state_reg)
            ST_IDLE: begin
                rt_ready_next = 1'b1;
                if (rt_valid && rt_ready_reg) begin
                    adr_next      = rt_adr;
                    dat_w_next    = rt_dat_w;
                    we_next       = rt_we;
                    rt_ready_next = 1'b0;
                    if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                    end else begin
                        state_next = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 8'd0) begin
                    state_next = ST_ACCESS;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            ST_ACCESS: begin
                state_next     = ST_RESP;
                rsp_valid_next = 1'b1;
                err_next       = !mapped;
                dat_r_next     = (mapped && !we_reg) ? rd_data : '0;
            end
            ST_RESP: begin
                if (rt_rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    err_next       = 1'b0;
                    rt_ready_next  = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 8'd0;
            rt_ready_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            dat_r_reg     <= '0;
            err_reg       <= 1'b0;
            adr_reg       <= '0;
            dat_w_reg     <= '0;
            we_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rt_ready_reg  <= rt_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            dat_r_reg     <= dat_r_next;
            err_reg       <= err_next;
            adr_reg       <= adr_next;
            dat_w_reg     <= dat_w_next;
            we_reg        <= we_next;
        end
    end

    // Unmapped addresses never match any gi, so no strobe or write can occur for them.
    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_reg
            assign wr_stb[gi] = (state_reg == ST_ACCESS) && we_reg && (adr_reg == ADR_WIDTH'(gi));

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    regs_reg[gi] <= RESET_VAL;
                end else if (wr_stb[gi]) begin
                    regs_reg[gi] <= dat_w_reg;
                end
            end

            assign regs_o[DAT_WIDTH*gi +: DAT_WIDTH] = regs_reg[gi];
        end
    endgenerate

    assign wr_stb_o     = wr_stb;
    assign rt_ready     = rt_ready_reg;
    assign rt_rsp_valid = rsp_valid_reg;
    assign rt_dat_r     = dat_r_reg;
    assign rt_err       = err_reg;

endmodule

// File: tb/tb_rv_addr_line_en_target_regs.sv
// Bench for rv_addr_line_en_target_regs: two instances (0 and 3 wait states) share one
// stimulus bus, and a timestamp-based transaction model predicts every output per cycle.
module tb_rv_addr_line_en_target_regs;

    localparam int          NR = 8;
    localparam logic [31:0] RV = 32'hC0DE_0001;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        sel;
    logic [3:0]  rt_adr;
    logic [31:0] rt_dat_w;
    logic        rt_we, rt_valid, rt_rsp_ready;

    logic        v0, v1, rr0, rr1;
    logic        rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] dr0, dr1;
    logic [255:0] regs0, regs1;
    logic [7:0]  stb0, stb1;

    assign v0  = rt_valid && !sel;
    assign v1  = rt_valid && sel;
    assign rr0 = rt_rsp_ready && !sel;
    assign rr1 = rt_rsp_ready && sel;

    rv_addr_line_en_target_regs #(.ADR_WIDTH(4), .DAT_WIDTH(32), .N_REGS(NR), .WAIT_STATES(0), .RESET_VAL(RV)) dut0 (
        .clock(clock), .reset(reset), .rt_adr(rt_adr), .rt_dat_w(rt_dat_w), .rt_we(rt_we),
        .rt_valid(v0), .rt_ready(rdy0), .rt_dat_r(dr0), .rt_err(er0), .rt_rsp_valid(rv0),
        .rt_rsp_ready(rr0), .regs_o(regs0), .wr_stb_o(stb0)
    );

    rv_addr_line_en_target_regs #(.ADR_WIDTH(4), .DAT_WIDTH(32), .N_REGS(NR), .WAIT_STATES(3), .RESET_VAL(RV)) dut1 (
        .clock(clock), .reset(reset), .rt_adr(rt_adr), .rt_dat_w(rt_dat_w), .rt_we(rt_we),
        .rt_valid(v1), .rt_ready(rdy1), .rt_dat_r(dr1), .rt_err(er1), .rt_rsp_valid(rv1),
        .rt_rsp_ready(rr1), .regs_o(regs1), .wr_stb_o(stb1)
    );

    logic        ready_s, rv_s, er_s;
    logic [31:0] dr_s;
    logic [7:0]  stb_s;
    assign ready_s = sel ? rdy1 : rdy0;
    assign rv_s    = sel ? rv1  : rv0;
    assign er_s    = sel ? er1  : er0;
    assign dr_s    = sel ? dr1  : dr0;
    assign stb_s   = sel ? stb1 : stb0;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t act=0x%08h exp=0x%08h", nm, $time, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s t=%0t act=timeout exp=handshake", nm, $time);
    endtask

    // Model: a transaction accepted at edge acc performs its access in cycle acc+ws,
    // commits at edge acc+ws+1, and its response is valid from then until the handshake.
    int          c = 0;
    bit          busy = 0;
    int          acc = 0;
    logic [3:0]  t_adr;
    logic [31:0] t_dat;
    bit          t_we;
    logic [31:0] exp_rd;
    bit          exp_er;
    logic [31:0] mregs [2][NR];
    int          ntxn = 0;

    always @(negedge clock) begin : model
        int          ws;
        logic        exp_ready, exp_rv;
        logic [7:0]  exp_stb;
        ws = sel ? 3 : 0;
        if (!reset) begin
            busy = 0;
            c    = 0;
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < NR; k++) mregs[s][k] = RV;
            chk("rst_dat_r", dr_s, 32'h0);
        end
        exp_ready = !busy && (c >= 1);
        exp_rv    = busy && (c >= acc + ws + 1);
        exp_stb   = 8'h00;
        if (busy && c == acc + ws && t_we && t_adr < NR) exp_stb[t_adr[2:0]] = 1'b1;
        chk("rt_ready", ready_s, exp_ready);
        chk("rt_rsp_valid", rv_s, exp_rv);
        chk("rt_err", er_s, exp_rv ? exp_er : 1'b0);
        chk("wr_stb_o", stb_s, exp_stb);
        chk("idle_wr_stb_o", sel ? stb0 : stb1, 32'h0);
        if (exp_rv) chk("rt_dat_r", dr_s, exp_rd);
        for (int k = 0; k < NR; k++) begin
            chk("regs_o_dut0", regs0[32*k +: 32], mregs[0][k]);
            chk("regs_o_dut1", regs1[32*k +: 32], mregs[1][k]);
        end
        if (reset) begin
            if (busy) begin
                if (c == acc + ws) begin
                    exp_er = !(t_adr < NR);
                    exp_rd = (t_adr < NR && !t_we) ? mregs[sel][t_adr[2:0]] : 32'h0;
                    if (t_adr < NR && t_we) mregs[sel][t_adr[2:0]] = t_dat;
                end else if (exp_rv && rt_rsp_ready) begin
                    busy = 0;
                    ntxn++;
                    $display("TXN dut_ws=%0d %s adr=%0d wdat=0x%08h rdat=0x%08h err=%0d",
                             ws, t_we ? "WR" : "RD", t_adr, t_dat, exp_rd, exp_er);
                end
            end else if (exp_ready && rt_valid) begin
                busy  = 1;
                acc   = c + 1;
                t_adr = rt_adr;
                t_dat = rt_dat_w;
                t_we  = rt_we;
            end
            c++;
        end
    end

    int          lat;
    logic [31:0] rd;
    logic        er;

    // Called at 1 time unit after a posedge; returns there after the response handshake.
    // mode 0: rsp_ready high, 1: random backpressure, 2: hold rsp_ready low 10 cycles.
    task automatic send(input bit s, input logic [3:0] a, input logic [31:0] d, input bit w, input int mode);
        bit ok;
        bit seen;
        int held;
        sel = s; rt_adr = a; rt_dat_w = d; rt_we = w; rt_valid = 1'b1;
        rt_rsp_ready = (mode == 0);
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clock);
            ok = ready_s;
            @(posedge clock); #1;
        end
        if (!ok) begin
            fail("accept_wait");
            rt_valid = 1'b0;
            return;
        end
        rt_valid = 1'b0;
        if (mode == 2) begin
            rt_valid = 1'b1; rt_adr = a ^ 4'd1; rt_dat_w = ~d; rt_we = 1'b1;
        end
        seen = 0; held = 0; ok = 0; lat = 0;
        for (int n = 1; n <= 400 && !ok; n++) begin
            @(negedge clock);
            if (rv_s && !seen) begin
                seen = 1; lat = n; rd = dr_s; er = er_s;
            end
            ok = rv_s && rt_rsp_ready;
            if (mode == 2 && seen && !ok) begin
                chk("bp_hold_valid", rv_s, 1'b1);
                chk("bp_hold_dat", dr_s, rd);
            end
            @(posedge clock); #1;
            if (mode == 1) rt_rsp_ready = 1'($urandom_range(0, 1));
            else if (mode == 2) begin
                if (seen) held++;
                rt_rsp_ready = (held >= 10);
            end
        end
        rt_rsp_ready = 1'b0;
        rt_valid     = 1'b0;
        if (!ok) fail("response_wait");
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog t=%0t act=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit ok;
        int acc_t [1:3];
        int base;
        sel = 0; rt_adr = '0; rt_dat_w = '0; rt_we = 0; rt_valid = 0; rt_rsp_ready = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready0", rdy0, 1'b0);
        chk("rst_ready1", rdy1, 1'b0);
        chk("rst_rsp_valid", rv0 | rv1, 1'b0);
        chk("rst_err", er0 | er1, 1'b0);
        chk("rst_reg3", regs0[127:96], RV);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("release_ready0", rdy0, 1'b1);
        chk("release_ready1", rdy1, 1'b1);

        // Read after reset with 3 wait states.
        send(1, 4'd0, 32'h0, 0, 0);
        chk("ws3_read_lat", lat, 5);
        chk("ws3_read_dat", rd, RV);
        chk("ws3_read_err", er, 0);

        // Write then read, no wait states.
        send(0, 4'd2, 32'hDEADBEEF, 1, 0);
        chk("ws0_write_lat", lat, 2);
        chk("ws0_write_err", er, 0);
        chk("ws0_reg2", regs0[95:64], 32'hDEADBEEF);
        send(0, 4'd2, 32'h0, 0, 0);
        chk("ws0_read_lat", lat, 2);
        chk("ws0_read_dat", rd, 32'hDEADBEEF);
        chk("ws0_read_err", er, 0);

        // Unmapped address.
        send(0, 4'd9, 32'h1234, 1, 0);
        chk("unmapped_wr_err", er, 1);
        send(0, 4'd9, 32'h0, 0, 0);
        chk("unmapped_rd_err", er, 1);
        chk("unmapped_rd_dat", rd, 32'h0);

        // Response backpressure.
        send(0, 4'd5, 32'hA5A5A5A5, 1, 0);
        send(0, 4'd5, 32'h0, 0, 2);
        chk("bp_read_dat", rd, 32'hA5A5A5A5);
        chk("bp_read_lat", lat, 2);

        // Back-to-back writes with rt_valid held high.
        base = ntxn;
        sel = 0; rt_rsp_ready = 1; rt_adr = 4'd1; rt_we = 1; rt_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            rt_dat_w = i;
            ok = 0;
            acc_t[i] = 0;
            for (int n = 0; n < 50 && !ok; n++) begin
                @(negedge clock);
                ok = ready_s;
                if (ok) acc_t[i] = edge_cnt + 1;
                @(posedge clock); #1;
            end
            if (!ok) fail("b2b_accept");
        end
        rt_valid = 0;
        repeat (4) @(posedge clock);
        #1;
        rt_rsp_ready = 0;
        chk("b2b_gap1", acc_t[2] - acc_t[1], 3);
        chk("b2b_gap2", acc_t[3] - acc_t[2], 3);
        chk("b2b_rsps", ntxn - base, 3);
        chk("b2b_reg1", regs0[63:32], 32'd3);

        // Randomized traffic on both instances.
        for (int i = 0; i < 80; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int j = 0; j < gap; j++) begin
                @(posedge clock); #1;
            end
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 1));
        end

        // Reset during the wait phase of a write.
        send(1, 4'd4, 32'h55, 1, 0);
        chk("pre_reset_reg4", regs1[159:128], 32'h55);
        sel = 1; rt_adr = 4'd4; rt_dat_w = 32'hFF; rt_we = 1; rt_valid = 1;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clock);
            ok = ready_s;
            @(posedge clock); #1;
        end
        if (!ok) fail("reset_txn_accept");
        rt_valid = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("midreset_ready", rdy1, 1'b0);
        chk("midreset_reg4", regs1[159:128], RV);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        chk("release_ready_low", rdy1, 1'b0);
        @(posedge clock); #1;
        chk("release_ready_high", rdy1, 1'b1);
        repeat (8) @(posedge clock);
        #1;
        chk("no_response", rv1, 1'b0);
        chk("post_reset_reg4", regs1[159:128], RV);
        send(1, 4'd4, 32'h0, 0, 0);
        chk("post_reset_read4", rd, RV);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
